// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants and the buffer-swap handshake state type
// shared by the VGA scan controller and its raster counter.
package vga_pkg;

   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      ACK_WAIT
   } swap_state_t;

endpackage

// File: rtl/raster_counter.sv
// Pixel-tick enabled x/y raster position counter; also exposes the next position
// so the parent can register decodes that line up with the presented x/y.
module raster_counter #(
   parameter int H_TOTAL = 800,
   parameter int V_TOTAL = 525
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       tick,
   output logic [$clog2(H_TOTAL)-1:0] x,
   output logic [$clog2(V_TOTAL)-1:0] y,
   output logic [$clog2(H_TOTAL)-1:0] x_next,
   output logic [$clog2(V_TOTAL)-1:0] y_next,
   output logic                       line_wrap,
   output logic                       frame_wrap
);

   localparam int XW = $clog2(H_TOTAL);
   localparam int YW = $clog2(V_TOTAL);
   localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      line_wrap  = tick && (x_q == X_LAST);
      frame_wrap = line_wrap && (y_q == Y_LAST);
      if (line_wrap) begin
         x_d = '0;
         y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else if (tick) begin
         x_d = x_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x      = x_q;
   assign y      = y_q;
   assign x_next = x_d;
   assign y_next = y_d;

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: pixel prescaler, registered sync/active decode and the
// vblank-committed frame-buffer swap handshake. Optional VGA_SCAN_LINE_IRQ_EN adds line_irq.
module vga_scan_ctrl
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic                                               clock,
   input  logic                                               reset,
   input  logic                                               swap_req,
   output logic                                               swap_ack,
   output logic                                               front_buf,
   output logic                                               pixel_tick,
   output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]       x,
   output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]       y,
   output logic                                               hsync,
   output logic                                               vsync,
   output logic                                               active,
   output logic                                               frame_start
`ifdef VGA_SCAN_LINE_IRQ_EN
   ,
   input  logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]       line_match,
   output logic                                               line_irq
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int XW      = $clog2(H_TOTAL);
   localparam int YW      = $clog2(V_TOTAL);
   localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [XW-1:0] H_ACT_END  = XW'(H_ACTIVE);
   localparam logic [XW-1:0] HS_START   = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] HS_END     = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [YW-1:0] V_ACT_END  = YW'(V_ACTIVE);
   localparam logic [YW-1:0] VS_START   = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] VS_END     = YW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [YW-1:0] V_ACT_LAST = YW'(V_ACTIVE - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          active_q, active_d;
   logic          frame_start_q, frame_start_d;
   logic          swap_ack_q, swap_ack_d;
   logic          front_buf_q, front_buf_d;
   swap_state_t   state_q, state_d;

   logic [XW-1:0] x_next;
   logic [YW-1:0] y_next;
   logic          line_wrap, frame_wrap, vblank_edge, commit;

   raster_counter #(
      .H_TOTAL(H_TOTAL),
      .V_TOTAL(V_TOTAL)
   ) u_raster (
      .clock      (clock),
      .reset      (reset),
      .tick       (tick_q),
      .x          (x),
      .y          (y),
      .x_next     (x_next),
      .y_next     (y_next),
      .line_wrap  (line_wrap),
      .frame_wrap (frame_wrap)
   );

   // Tick is registered from the next prescaler value so it is high exactly while presc_q is CLK_DIV-1.
   always_comb begin
      presc_d       = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      tick_d        = (presc_d == PRESC_LAST);
      hsync_d       = !((x_next >= HS_START) && (x_next < HS_END));
      vsync_d       = !((y_next >= VS_START) && (y_next < VS_END));
      active_d      = (x_next < H_ACT_END) && (y_next < V_ACT_END);
      frame_start_d = frame_wrap;
   end

   assign vblank_edge = line_wrap && (y == V_ACT_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (swap_req) state_d = vblank_edge ? ACK_WAIT : PENDING;
         PENDING:  if (vblank_edge) state_d = ACK_WAIT;
         ACK_WAIT: if (!swap_req) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // A request seen in IDLE on the vblank edge itself commits without waiting a frame.
   always_comb begin
      commit      = vblank_edge && (((state_q == IDLE) && swap_req) || (state_q == PENDING));
      swap_ack_d  = commit;
      front_buf_d = front_buf_q ^ commit;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q       <= '0;
         tick_q        <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         active_q      <= 1'b1;
         frame_start_q <= 1'b0;
         swap_ack_q    <= 1'b0;
         front_buf_q   <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         tick_q        <= tick_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         frame_start_q <= frame_start_d;
         swap_ack_q    <= swap_ack_d;
         front_buf_q   <= front_buf_d;
      end
   end

   assign pixel_tick  = tick_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign active      = active_q;
   assign frame_start = frame_start_q;
   assign swap_ack    = swap_ack_q;
   assign front_buf   = front_buf_q;

`ifdef VGA_SCAN_LINE_IRQ_EN
   logic line_irq_q, line_irq_d;

   assign line_irq_d = line_wrap && (y_next == line_match);

   always_ff @(posedge clock) begin
      if (reset) begin
         line_irq_q <= 1'b0;
      end else begin
         line_irq_q <= line_irq_d;
      end
   end

   assign line_irq = line_irq_q;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl using a reduced 16x12 raster so whole frames fit
// in a short run; also exercises line_irq when VGA_SCAN_LINE_IRQ_EN is defined.
module tb_vga_scan_ctrl;

   localparam int D   = 2;
   localparam int HA  = 8;
   localparam int HFP = 2;
   localparam int HS  = 3;
   localparam int HBP = 3;
   localparam int VA  = 6;
   localparam int VFP = 2;
   localparam int VS  = 2;
   localparam int VBP = 2;
   localparam int HT  = HA + HFP + HS + HBP;
   localparam int VT  = VA + VFP + VS + VBP;
   localparam int FRAME = D * HT * VT;

   typedef struct {
      int         cyc;
      logic [3:0] ex;
      logic [3:0] ey;
      logic       etick;
      logic       ehs;
      logic       evs;
      logic       eact;
      logic       efs;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       swap_req = 1'b0;
   logic       swap_ack, front_buf, pixel_tick, hsync, vsync, active, frame_start;
   logic [3:0] x;
   logic [3:0] y;
`ifdef VGA_SCAN_LINE_IRQ_EN
   logic [3:0] line_match = 4'd5;
   logic       line_irq;
`endif

   int tests = 0;
   int fails = 0;

   // Reference model state: clocks since reset release, plus swap bookkeeping.
   int c = 0;
   bit m_fb = 1'b0;
   bit m_ack = 1'b0;
   bit m_dropped = 1'b1;

   always #5 clock = ~clock;

   vga_scan_ctrl #(
      .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .front_buf   (front_buf),
      .pixel_tick  (pixel_tick),
      .x           (x),
      .y           (y),
      .hsync       (hsync),
      .vsync       (vsync),
      .active      (active),
      .frame_start (frame_start)
`ifdef VGA_SCAN_LINE_IRQ_EN
      ,
      .line_match  (line_match),
      .line_irq    (line_irq)
`endif
   );

   function automatic int m_x();
      return (c / D) % HT;
   endfunction

   function automatic int m_y();
      return ((c / D) / HT) % VT;
   endfunction

   function automatic bit m_tick();
      return (c > 0) && ((c % D) == D - 1);
   endfunction

   function automatic bit m_moved();
      return (c > 0) && ((c % D) == 0);
   endfunction

   function automatic bit m_vblank();
      return m_tick() && (m_x() == HT - 1) && (m_y() == VA - 1);
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at c=%0d: actual=%0h required=%0h", name, c, act, exp);
      end
   endtask

   task automatic checkOutput();
      logic [31:0] act_v, exp_v;
      logic        irq_act, irq_exp;
      bit          hs_e, vs_e, act_e;
      hs_e  = !((m_x() >= HA + HFP) && (m_x() < HA + HFP + HS));
      vs_e  = !((m_y() >= VA + VFP) && (m_y() < VA + VFP + VS));
      act_e = (m_x() < HA) && (m_y() < VA);
`ifdef VGA_SCAN_LINE_IRQ_EN
      irq_act = line_irq;
      irq_exp = m_moved() && (m_x() == 0) && (m_y() == int'(line_match));
`else
      irq_act = 1'b0;
      irq_exp = 1'b0;
`endif
      act_v = {16'h0, pixel_tick, x, y, hsync, vsync, active, frame_start, swap_ack, front_buf, irq_act};
      exp_v = {16'h0, m_tick(), 4'(m_x()), 4'(m_y()), hs_e, vs_e, act_e,
               m_moved() && (m_x() == 0) && (m_y() == 0), m_ack, m_fb, irq_exp};
      checkValue("model", act_v, exp_v);
   endtask

   // One clock: drive inputs, advance the model across the edge, compare at the falling edge.
   task automatic applyStimulus(input logic req_v, input logic rst_v);
      swap_req = req_v;
      reset    = rst_v;
      @(posedge clock);
      if (rst_v) begin
         c         = 0;
         m_fb      = 1'b0;
         m_ack     = 1'b0;
         m_dropped = 1'b1;
      end else begin
         if (!req_v) m_dropped = 1'b1;
         m_ack = m_vblank() && req_v && m_dropped;
         if (m_ack) begin
            m_fb      = ~m_fb;
            m_dropped = 1'b0;
         end
         c++;
      end
      @(negedge clock);
      checkOutput();
   endtask

   vec_t vecs[13];

   initial begin
      int  acks;
      bit  found;
      bit  req;
      bit  acked;

      vecs[0]  = '{0,   4'd0,  4'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{1,   4'd0,  4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{2,   4'd1,  4'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{20,  4'd10, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{25,  4'd12, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{26,  4'd13, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{32,  4'd0,  4'd1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{256, 4'd0,  4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{318, 4'd15, 4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{320, 4'd0,  4'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{383, 4'd15, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{384, 4'd0,  4'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[12] = '{385, 4'd0,  4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      repeat (3) applyStimulus(1'b0, 1'b1);
      checkValue("reset_state", {x, y, pixel_tick, hsync, vsync, active, frame_start, swap_ack, front_buf},
                 {4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

      foreach (vecs[i]) begin
         for (int k = 0; k < 500 && c < vecs[i].cyc; k++) applyStimulus(1'b0, 1'b0);
         checkValue($sformatf("vec%0d", i), {pixel_tick, x, y, hsync, vsync, active, frame_start},
                    {vecs[i].etick, vecs[i].ex, vecs[i].ey, vecs[i].ehs, vecs[i].evs, vecs[i].eact, vecs[i].efs});
      end

      // Request raised mid-frame and held across two vblank edges: exactly one swap.
      found = 1'b0;
      for (int k = 0; k < FRAME && !found; k++) begin
         applyStimulus(1'b0, 1'b0);
         found = (m_y() == 2) && (m_x() == 0);
      end
      checkValue("wait_hold_start", {31'h0, found}, 32'h1);
      acks = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         applyStimulus(1'b1, 1'b0);
         if (swap_ack) acks++;
      end
      checkValue("hold_ack_count", acks, 1);
      checkValue("hold_front_buf", {31'h0, front_buf}, 32'h1);
      acks = 0;
      for (int k = 0; k < FRAME + 10; k++) begin
         applyStimulus(1'b0, 1'b0);
         if (swap_ack) acks++;
      end
      checkValue("after_drop_acks", acks, 0);
      checkValue("after_drop_front_buf", {31'h0, front_buf}, 32'h1);

      // Reset while a swap is pending discards it.
      found = 1'b0;
      for (int k = 0; k < FRAME && !found; k++) begin
         applyStimulus(1'b0, 1'b0);
         found = (m_y() == 2) && (m_x() == 0);
      end
      checkValue("wait_pend_start", {31'h0, found}, 32'h1);
      found = 1'b0;
      for (int k = 0; k < FRAME && !found; k++) begin
         applyStimulus(1'b1, 1'b0);
         found = (m_y() == 3) && (m_x() == 8);
      end
      checkValue("wait_pend_mid", {31'h0, found}, 32'h1);
      applyStimulus(1'b0, 1'b1);
      checkValue("midreset_state", {x, y, front_buf, swap_ack, frame_start},
                 {4'd0, 4'd0, 1'b0, 1'b0, 1'b0});
      acks = 0;
      for (int k = 0; k < FRAME + 10; k++) begin
         applyStimulus(1'b0, 1'b0);
         if (swap_ack) acks++;
      end
      checkValue("midreset_no_swap", acks, 0);

      // Request that first appears on the vblank-edge cycle commits on that edge.
      found = m_vblank();
      for (int k = 0; k < FRAME && !found; k++) begin
         applyStimulus(1'b0, 1'b0);
         found = m_vblank();
      end
      checkValue("wait_vblank", {31'h0, found}, 32'h1);
      applyStimulus(1'b1, 1'b0);
      checkValue("same_cycle_ack", {31'h0, swap_ack}, 32'h1);
      checkValue("same_cycle_front_buf", {31'h0, front_buf}, 32'h1);
      checkValue("same_cycle_pos", {x, y}, {4'd0, 4'(VA)});
      repeat (10) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);

`ifdef VGA_SCAN_LINE_IRQ_EN
      line_match = 4'(VA - 1);
      acks = 0;
      for (int k = 0; k < FRAME; k++) begin
         applyStimulus(1'b0, 1'b0);
         if (line_irq) begin
            acks++;
            checkValue("irq_pos", {x, y}, {4'd0, 4'(VA - 1)});
         end
      end
      checkValue("irq_count", acks, 1);
      line_match = 4'd14;
      acks = 0;
      for (int k = 0; k < FRAME; k++) begin
         applyStimulus(1'b0, 1'b0);
         if (line_irq) acks++;
      end
      checkValue("irq_out_of_range", acks, 0);
      line_match = 4'($urandom_range(0, VT - 1));
`endif

      // Randomized requests that obey the handshake, compared cycle by cycle with the model.
      req   = 1'b0;
      acked = 1'b0;
      for (int k = 0; k < 6 * FRAME; k++) begin
         if (!req && $urandom_range(0, 99) == 0) begin
            req = 1'b1;
         end else if (req && acked && $urandom_range(0, 29) == 0) begin
            req   = 1'b0;
            acked = 1'b0;
         end
         if ($urandom_range(0, 2999) == 0) begin
            applyStimulus(1'b0, 1'b1);
            req   = 1'b0;
            acked = 1'b0;
         end else begin
            applyStimulus(req, 1'b0);
            if (m_ack) acked = 1'b1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
